// File: rtl/mem_bus_ctrl.sv
// Memory-bus sequencer: IDLE -> SETUP -> ACCESS -> HOLD -> DONE with active-low SRAM strobes,
// per-byte enables, mem_ready wait with optional timeout, and masked read-data capture.
module mem_bus_ctrl #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int BE_W      = DATA_W / 8,
  parameter int SETUP_CYC = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_oe,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              mem_ready,
  output logic              Mem_CE,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic [BE_W-1:0]   Mem_BE,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // One counter serves both the setup phase and the ACCESS wait; it is cleared on entry to each.
  localparam int SW    = $clog2(SETUP_CYC + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int CW_A  = (SW > TW) ? SW : TW;
  localparam int CNT_W = (CW_A < 1) ? 1 : CW_A;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_masked;
  logic              active;

  always_comb begin
    rd_masked = '0;
    for (int i = 0; i < BE_W; i++) begin
      if (be_q[i]) rd_masked[i*8 +: 8] = Data_in[i*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACCESS: begin
        // mem_ready takes priority over a timeout landing on the same cycle.
        if (mem_ready) begin
          state_d = S_HOLD;
          if (!we_q) rdata_d = rd_masked;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d = S_HOLD;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    active    = (state_q == S_SETUP) || (state_q == S_ACCESS) || (state_q == S_HOLD);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    err       = (state_q == S_DONE) && err_q;
    Mem_CE    = !active;
    Mem_OE    = !((state_q == S_ACCESS) && !we_q);
    Mem_WE    = !((state_q == S_ACCESS) && we_q);
    Mem_BE    = active ? ~be_q : '1;
    Data_oe   = active && we_q;
    rdata     = rdata_q;
    ADDR      = addr_q;
    Data_out  = wdata_q;
    dbg_state = state_q;
  end

endmodule
